// File: rtl/rs232_pkg.sv
// Shared types and constants for the RS-232 transmit scheduler.
package rs232_pkg;

  // Scheduler phases: no byte held / byte offered / transmitter busy with it
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } tx_state_e;

  localparam int unsigned DATA_W_DEF = 8;

  // Supported requester count range for the round-robin picker
  localparam int unsigned RR_MIN_REQ = 2;
  localparam int unsigned RR_MAX_REQ = 8;

  // Index width for a round-robin picker over n requesters (at least 1 bit)
  function automatic int unsigned rr_idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches upward from ptr+1 with wrap.
module rr_arbiter
  import rs232_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = rr_idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  // First requester after ptr (wrapping) wins; the one at ptr itself is checked last
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((32'(ptr) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rs232_tx_scheduler.sv
// Round-robin scheduler sharing one RS-232 byte transmitter among NUM_REQ
// byte sources, with bounded per-grant bursts so messages are not interleaved.
module rs232_tx_scheduler
  import rs232_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        tx_valid,
  output logic [DATA_W-1:0]           tx_data,
  input  logic                        tx_ready,
  input  logic                        tx_done,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  tx_state_e          state;
  logic [IDX_W-1:0]   ptr;
  logic [CNT_W-1:0]   burst_cnt;
  logic               hold_last;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic [IDX_W-1:0]   sel_idx;
  logic [DATA_W-1:0]  sel_data;
  logic               sel_last;
  logic               cont_ok;
  logic               take_idle;
  logic               take_cont;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  // Accept decisions: new grant from IDLE, or burst continuation on tx_done
  always_comb begin
    cont_ok   = !hold_last && (burst_cnt < CNT_W'(MAX_BURST)) && req_valid[grant_id];
    take_idle = rst_n && (state == ST_IDLE) && (|req_valid);
    take_cont = rst_n && (state == ST_WAIT) && tx_done && cont_ok;
  end

  // One-hot accept strobe; gated by reset so nothing is taken while in reset
  always_comb begin
    req_ready = '0;
    if (take_idle) begin
      req_ready = arb_grant;
    end else if (take_cont) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  // Select the byte/last flag of the requester being accepted this cycle
  always_comb begin
    sel_idx  = (state == ST_IDLE) ? arb_idx : grant_id;
    sel_data = '0;
    sel_last = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == sel_idx) begin
        sel_data = req_data[i*DATA_W +: DATA_W];
        sel_last = req_last[i];
      end
    end
  end

  // Scheduler FSM; tx_data doubles as the byte hold register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ptr       <= IDX_W'(NUM_REQ - 1);
      burst_cnt <= '0;
      hold_last <= 1'b0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      grant_id  <= '0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (take_idle) begin
            tx_data   <= sel_data;
            hold_last <= sel_last;
            grant_id  <= arb_idx;
            burst_cnt <= CNT_W'(1);
            tx_valid  <= 1'b1;
            busy      <= 1'b1;
            state     <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (tx_done) begin
            if (cont_ok) begin
              tx_data   <= sel_data;
              hold_last <= sel_last;
              burst_cnt <= burst_cnt + 1'b1;
              tx_valid  <= 1'b1;
              state     <= ST_SEND;
            end else begin
              ptr   <= grant_id;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          tx_valid <= 1'b0;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
